// File: rtl/systolic_tile_sequencer.sv
// Producer/consumer around one systolic tile job: operand buffers feed the row and
// column streams after a CSR start, and result beats are captured into a result buffer.
module systolic_tile_sequencer #(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock_sink,
   input  logic                  reset_sink_reset,
   input  logic [7:0]            csr_address,
   input  logic                  csr_write,
   input  logic [31:0]           csr_writedata,
   input  logic                  csr_read,
   output logic [31:0]           csr_readdata,
   input  logic                  ld_write,
   input  logic                  ld_sel,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic [ADDR_WIDTH-1:0] res_addr,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [31:0]           st_instr_data,
   output logic                  st_instr_valid,
   input  logic                  st_instr_ready,
   output logic [DATA_WIDTH-1:0] st_rows_data,
   output logic                  st_rows_valid,
   input  logic                  st_rows_ready,
   output logic [DATA_WIDTH-1:0] st_cols_data,
   output logic                  st_cols_valid,
   input  logic                  st_cols_ready,
   input  logic [DATA_WIDTH-1:0] data_out_data,
   input  logic                  data_out_valid,
   output logic                  data_out_ready
);
   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_COLLECT, S_DONE} state_e;

   state_e                state_q;
   logic [CW-1:0]         len_q, n_q, row_ptr_q, col_ptr_q, res_count_q;
   logic [31:0]           cyc_count_q, instr_data_q;
   logic                  done_q, err_q, done_d, err_d;
   logic                  instr_valid_q, rows_valid_q, cols_valid_q, dout_ready_q;
   logic [DATA_WIDTH-1:0] rows_data_q, cols_data_q;

   logic [DATA_WIDTH-1:0] row_buf [DEPTH];
   logic [DATA_WIDTH-1:0] col_buf [DEPTH];
   logic [DATA_WIDTH-1:0] res_buf [DEPTH];

   logic          busy, ctrl_wr, len_wr, start, clr, len_bad;
   logic          row_xfer, col_xfer, res_xfer, rows_last, cols_last, stream_end;
   logic [CW-1:0] row_nxt, col_nxt, res_nxt;
   logic [11:0]   n12;

   assign busy    = (state_q != S_IDLE);
   assign ctrl_wr = csr_write && (csr_address == 8'd0);
   assign len_wr  = csr_write && (csr_address == 8'd1);
   assign start   = ctrl_wr && csr_writedata[0];
   assign clr     = ctrl_wr && csr_writedata[1];
   assign len_bad = len_wr && ((csr_writedata == 32'd0) || (csr_writedata > 32'(DEPTH)));
   assign n12     = 12'(len_q);

   assign row_xfer   = rows_valid_q && st_rows_ready;
   assign col_xfer   = cols_valid_q && st_cols_ready;
   assign res_xfer   = dout_ready_q && data_out_valid;
   assign row_nxt    = row_ptr_q + 1'b1;
   assign col_nxt    = col_ptr_q + 1'b1;
   assign res_nxt    = res_count_q + 1'b1;
   assign rows_last  = row_xfer && (row_nxt == n_q);
   assign cols_last  = col_xfer && (col_nxt == n_q);
   // Each stream is finished either earlier (valid already low) or on this edge.
   assign stream_end = (!rows_valid_q || rows_last) && (!cols_valid_q || cols_last);

   assign st_instr_data  = instr_data_q;
   assign st_instr_valid = instr_valid_q;
   assign st_rows_data   = rows_data_q;
   assign st_rows_valid  = rows_valid_q;
   assign st_cols_data   = cols_data_q;
   assign st_cols_valid  = cols_valid_q;
   assign data_out_ready = dout_ready_q;
   assign res_data       = res_buf[res_addr];

   // Clear is applied before any error/done event raised in the same cycle.
   always_comb begin
      err_d = clr ? 1'b0 : err_q;
      if ((start && busy) || (ld_write && busy) || len_bad) err_d = 1'b1;
      done_d = clr ? 1'b0 : done_q;
      if (start && !busy) done_d = 1'b0;
      if (state_q == S_DONE) done_d = 1'b1;
   end

   always_comb begin
      csr_readdata = '0;
      if (csr_read) begin
         case (csr_address)
            8'd0:    csr_readdata = {29'd0, err_q, done_q, busy};
            8'd1:    csr_readdata = 32'(len_q);
            8'd2:    csr_readdata = 32'(res_count_q);
            8'd3:    csr_readdata = cyc_count_q;
            default: csr_readdata = '0;
         endcase
      end
   end

   // Buffers carry no reset so they can map onto plain RAM.
   always_ff @(posedge clock_sink) begin
      if (ld_write && !busy) begin
         if (ld_sel) col_buf[ld_addr] <= ld_data;
         else        row_buf[ld_addr] <= ld_data;
      end
      if (res_xfer) res_buf[res_count_q[ADDR_WIDTH-1:0]] <= data_out_data;
   end

   always_ff @(posedge clock_sink or posedge reset_sink_reset) begin
      if (reset_sink_reset) begin
         state_q       <= S_IDLE;
         len_q         <= CW'(DEPTH);
         n_q           <= CW'(DEPTH);
         row_ptr_q     <= '0;
         col_ptr_q     <= '0;
         res_count_q   <= '0;
         cyc_count_q   <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         instr_data_q  <= '0;
         instr_valid_q <= 1'b0;
         rows_valid_q  <= 1'b0;
         cols_valid_q  <= 1'b0;
         rows_data_q   <= '0;
         cols_data_q   <= '0;
         dout_ready_q  <= 1'b0;
      end else begin
         err_q  <= err_d;
         done_q <= done_d;
         if (len_wr && !len_bad) len_q <= csr_writedata[CW-1:0];
         if (busy && (state_q != S_DONE) && (cyc_count_q != '1))
            cyc_count_q <= cyc_count_q + 32'd1;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_ISSUE;
                  n_q           <= len_q;
                  instr_data_q  <= {8'd0, n12, n12};
                  instr_valid_q <= 1'b1;
                  res_count_q   <= '0;
                  cyc_count_q   <= '0;
               end
            end
            S_ISSUE: begin
               if (instr_valid_q && st_instr_ready) begin
                  state_q       <= S_STREAM;
                  instr_valid_q <= 1'b0;
                  row_ptr_q     <= '0;
                  col_ptr_q     <= '0;
                  rows_valid_q  <= 1'b1;
                  cols_valid_q  <= 1'b1;
                  rows_data_q   <= row_buf[0];
                  cols_data_q   <= col_buf[0];
               end
            end
            S_STREAM: begin
               if (row_xfer) begin
                  row_ptr_q <= row_nxt;
                  if (rows_last) rows_valid_q <= 1'b0;
                  else           rows_data_q  <= row_buf[row_nxt[ADDR_WIDTH-1:0]];
               end
               if (col_xfer) begin
                  col_ptr_q <= col_nxt;
                  if (cols_last) cols_valid_q <= 1'b0;
                  else           cols_data_q  <= col_buf[col_nxt[ADDR_WIDTH-1:0]];
               end
               if (stream_end) begin
                  state_q      <= S_COLLECT;
                  dout_ready_q <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (res_xfer) begin
                  res_count_q <= res_nxt;
                  if (res_nxt == n_q) begin
                     dout_ready_q <= 1'b0;
                     state_q      <= S_DONE;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer: directed jobs, expectations queued at
// issue time and popped by a monitor whenever a stream, CSR or result read is presented.
module tb_systolic_tile_sequencer;
   localparam int DW = 256;
   localparam int AW = 5;

   logic          clk = 1'b0, rst = 1'b1;
   logic [7:0]    csr_address;
   logic          csr_write, csr_read;
   logic [31:0]   csr_writedata, csr_readdata;
   logic          ld_write, ld_sel;
   logic [AW-1:0] ld_addr, res_addr;
   logic [DW-1:0] ld_data, res_data;
   logic [31:0]   st_instr_data;
   logic          st_instr_valid, st_instr_ready;
   logic [DW-1:0] st_rows_data, st_cols_data, data_out_data;
   logic          st_rows_valid, st_rows_ready, st_cols_valid, st_cols_ready;
   logic          data_out_valid, data_out_ready;

   systolic_tile_sequencer dut (
      .clock_sink(clk), .reset_sink_reset(rst),
      .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
      .csr_read(csr_read), .csr_readdata(csr_readdata),
      .ld_write(ld_write), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .res_addr(res_addr), .res_data(res_data),
      .st_instr_data(st_instr_data), .st_instr_valid(st_instr_valid), .st_instr_ready(st_instr_ready),
      .st_rows_data(st_rows_data), .st_rows_valid(st_rows_valid), .st_rows_ready(st_rows_ready),
      .st_cols_data(st_cols_data), .st_cols_valid(st_cols_valid), .st_cols_ready(st_cols_ready),
      .data_out_data(data_out_data), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
   );

   initial forever #5 clk = ~clk;

   typedef struct { string nm; logic [31:0] v; } csr_exp_t;

   int n_cmp = 0, n_bad = 0;
   logic [31:0] exp_instr[$];
   logic [DW-1:0] exp_row[$], exp_col[$], exp_res[$];
   csr_exp_t exp_csr[$];
   logic [DW-1:0] dq_d[$];
   int dq_gap[$];
   logic csr_chk = 1'b0, res_chk = 1'b0, col_toggle = 1'b0;
   logic dfire, ifire;
   int cyc = 0, row_fires = 0, rv_cyc = 0, cv_cyc = 0, last_col_cyc = 0;
   int first_rdy_cyc = -1, last_fire_cyc = 0, last_rdy_cyc = 0;

   function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic void unexpected(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: transfer with no expectation queued", nm);
   endfunction

   function automatic logic [DW-1:0] rowv(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {32{b}};
   endfunction

   function automatic logic [DW-1:0] colv(input int i, input logic alt);
      logic [7:0] b;
      b = alt ? 8'(8'h10 + i) : 8'h01;
      return {32{b}};
   endfunction

   function automatic logic [DW-1:0] dv(input int k, input int i);
      logic [31:0] w;
      w = 32'hD000_0000 + 32'(k * 16 + i);
      return {8{w}};
   endfunction

   // Monitor: checks every transfer and every flagged read against the queues.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (st_instr_valid && st_instr_ready) begin
            if (exp_instr.size() == 0) unexpected("instr");
            else chk("instr", 256'(st_instr_data), 256'(exp_instr.pop_front()));
         end
         if (st_rows_valid && st_rows_ready) begin
            row_fires++;
            if (exp_row.size() == 0) unexpected("row");
            else chk("row_beat", st_rows_data, exp_row.pop_front());
         end
         if (st_cols_valid && st_cols_ready) begin
            last_col_cyc = cyc;
            if (exp_col.size() == 0) unexpected("col");
            else chk("col_beat", st_cols_data, exp_col.pop_front());
         end
         if (st_rows_valid) rv_cyc++;
         if (st_cols_valid) cv_cyc++;
         if (data_out_ready) begin
            last_rdy_cyc = cyc;
            if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
         end
         if (data_out_valid && data_out_ready) last_fire_cyc = cyc;
         if (csr_chk && exp_csr.size() > 0) begin
            csr_exp_t e;
            e = exp_csr.pop_front();
            chk(e.nm, 256'(csr_readdata), 256'(e.v));
         end
         if (res_chk && exp_res.size() > 0) chk("res_data", res_data, exp_res.pop_front());
      end
      cyc++;
   end

   // Downstream model: presents queued result beats with optional leading gaps,
   // and optionally toggles column ready starting low on the first stream cycle.
   initial forever begin
      @(negedge clk);
      dfire = data_out_valid && data_out_ready;
      ifire = st_instr_valid && st_instr_ready;
      @(posedge clk);
      #1;
      if (dfire && dq_d.size() > 0) begin
         void'(dq_d.pop_front());
         void'(dq_gap.pop_front());
      end
      if (col_toggle) st_cols_ready = ifire ? 1'b0 : ~st_cols_ready;
      data_out_valid = 1'b0;
      if (dq_d.size() > 0) begin
         if (dq_gap[0] > 0) dq_gap[0] = dq_gap[0] - 1;
         else begin
            data_out_valid = 1'b1;
            data_out_data  = dq_d[0];
         end
      end
   end

   task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      @(posedge clk); #1;
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input string nm, input logic [7:0] a, input logic [31:0] v);
      csr_exp_t e;
      e.nm = nm; e.v = v;
      @(posedge clk); #1;
      exp_csr.push_back(e);
      csr_address = a; csr_read = 1'b1; csr_chk = 1'b1;
      @(posedge clk); #1;
      csr_read = 1'b0; csr_chk = 1'b0;
   endtask

   task automatic res_rd(input int i, input logic [DW-1:0] v);
      @(posedge clk); #1;
      exp_res.push_back(v);
      res_addr = AW'(i); res_chk = 1'b1;
      @(posedge clk); #1;
      res_chk = 1'b0;
   endtask

   task automatic ld(input logic sel, input int a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      ld_write = 1'b1; ld_sel = sel; ld_addr = AW'(a); ld_data = d;
      @(posedge clk); #1;
      ld_write = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      logic b;
      b = 1'b1;
      for (int i = 0; i < budget && b; i++) begin
         @(posedge clk); #1;
         csr_address = 8'd0; csr_read = 1'b1;
         @(negedge clk);
         b = csr_readdata[0];
      end
      @(posedge clk); #1;
      csr_read = 1'b0;
      chk("idle_wait", 256'(b), 256'(0));
   endtask

   task automatic expect_job(input logic alt);
      exp_instr.push_back(32'h0000_4004);
      for (int i = 0; i < 4; i++) begin
         exp_row.push_back(rowv(i));
         exp_col.push_back(colv(i, alt));
      end
   endtask

   task automatic push_beats(input int k, input int g0, input int g1, input int g2, input int g3);
      int g[4];
      g = '{g0, g1, g2, g3};
      for (int i = 0; i < 4; i++) begin
         dq_d.push_back(dv(k, i));
         dq_gap.push_back(g[i]);
      end
   endtask

   task automatic reset_stats();
      rv_cyc = 0; cv_cyc = 0; row_fires = 0; first_rdy_cyc = -1;
   endtask

   task automatic check_drained(input string nm);
      chk({nm, "_rows_left"}, 256'(exp_row.size()), 256'(0));
      chk({nm, "_cols_left"}, 256'(exp_col.size()), 256'(0));
      chk({nm, "_instr_left"}, 256'(exp_instr.size()), 256'(0));
   endtask

   task automatic check_res(input int k);
      for (int i = 0; i < 4; i++) res_rd(i, dv(k, i));
   endtask

   initial begin
      csr_address = '0; csr_write = 1'b0; csr_writedata = '0; csr_read = 1'b0;
      ld_write = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; res_addr = '0;
      st_instr_ready = 1'b1; st_rows_ready = 1'b1; st_cols_ready = 1'b1;
      data_out_valid = 1'b0; data_out_data = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_instr_valid", 256'(st_instr_valid), 256'(0));
      chk("rst_rows_valid", 256'(st_rows_valid), 256'(0));
      chk("rst_cols_valid", 256'(st_cols_valid), 256'(0));
      chk("rst_dout_ready", 256'(data_out_ready), 256'(0));
      chk("rst_rows_data", st_rows_data, '0);
      @(posedge clk); #1 rst = 1'b0;
      csr_rd("rst_ctrl", 8'd0, 32'd0);
      csr_rd("rst_len", 8'd1, 32'd32);
      csr_rd("rst_res", 8'd2, 32'd0);
      csr_rd("rst_cyc", 8'd3, 32'd0);
      csr_rd("unmapped", 8'd9, 32'd0);

      // Illegal LEN writes
      csr_wr(8'd1, 32'd0);
      csr_rd("len0_err", 8'd0, 32'h4);
      csr_wr(8'd1, 32'd33);
      csr_rd("len33_keep", 8'd1, 32'd32);
      csr_wr(8'd0, 32'd2);
      csr_rd("err_clear", 8'd0, 32'd0);

      // Job 1: all readys high
      for (int i = 0; i < 4; i++) begin
         ld(1'b0, i, rowv(i));
         ld(1'b1, i, colv(i, 1'b0));
      end
      csr_wr(8'd1, 32'd4);
      csr_rd("len4", 8'd1, 32'd4);
      expect_job(1'b0);
      push_beats(1, 0, 0, 0, 0);
      reset_stats();
      csr_wr(8'd0, 32'd1);
      wait_idle(200);
      csr_rd("j1_status", 8'd0, 32'h2);
      csr_rd("j1_res_count", 8'd2, 32'd4);
      csr_rd("j1_cyc_count", 8'd3, 32'd9);
      chk("j1_rows_valid_cycles", 256'(rv_cyc), 256'(4));
      chk("j1_cols_valid_cycles", 256'(cv_cyc), 256'(4));
      check_drained("j1");
      check_res(1);

      // Job 2: column ready toggling
      expect_job(1'b0);
      push_beats(2, 0, 0, 0, 0);
      reset_stats();
      col_toggle = 1'b1;
      csr_wr(8'd0, 32'd1);
      wait_idle(200);
      col_toggle = 1'b0;
      st_cols_ready = 1'b1;
      chk("j2_rows_valid_cycles", 256'(rv_cyc), 256'(4));
      chk("j2_cols_valid_cycles", 256'(cv_cyc), 256'(8));
      chk("j2_collect_after_cols", 256'(first_rdy_cyc > last_col_cyc), 256'(1));
      csr_rd("j2_status", 8'd0, 32'h2);
      check_drained("j2");

      // Job 3: gapped result beats plus a surplus 5th beat
      for (int i = 0; i < 4; i++) ld(1'b1, i, colv(i, 1'b1));
      expect_job(1'b1);
      push_beats(3, 0, 2, 1, 3);
      dq_d.push_back(dv(3, 4));
      dq_gap.push_back(0);
      reset_stats();
      csr_wr(8'd0, 32'd1);
      wait_idle(300);
      chk("j3_ready_drop", 256'(last_rdy_cyc), 256'(last_fire_cyc));
      chk("j3_beat5_pending", 256'(dq_d.size()), 256'(1));
      repeat (3) @(posedge clk);
      csr_rd("j3_res_count", 8'd2, 32'd4);
      check_drained("j3");
      check_res(3);
      @(posedge clk); #1;
      dq_d.delete(); dq_gap.delete();

      // Job 4: load and start while streaming
      expect_job(1'b1);
      push_beats(4, 0, 0, 0, 0);
      st_rows_ready = 1'b0;
      csr_wr(8'd0, 32'd1);
      ld(1'b0, 1, {32{8'hEE}});
      csr_wr(8'd0, 32'd1);
      csr_rd("j4_busy_err", 8'd0, 32'h5);
      st_rows_ready = 1'b1;
      wait_idle(200);
      csr_rd("j4_status", 8'd0, 32'h6);
      csr_rd("j4_res_count", 8'd2, 32'd4);
      check_drained("j4");
      check_res(4);
      csr_wr(8'd0, 32'd2);

      // Job 5: reset during row beat 2, then a clean job
      expect_job(1'b1);
      push_beats(5, 0, 0, 0, 0);
      reset_stats();
      csr_wr(8'd0, 32'd1);
      for (int i = 0; i < 50 && row_fires < 2; i++) begin
         @(posedge clk); #1;
      end
      chk("j5_reach_beat2", 256'(row_fires), 256'(2));
      rst = 1'b1;
      @(negedge clk);
      chk("j5_rst_rows_valid", 256'(st_rows_valid), 256'(0));
      chk("j5_rst_cols_valid", 256'(st_cols_valid), 256'(0));
      chk("j5_rst_instr_valid", 256'(st_instr_valid), 256'(0));
      chk("j5_rst_dout_ready", 256'(data_out_ready), 256'(0));
      exp_row.delete(); exp_col.delete(); exp_instr.delete();
      dq_d.delete(); dq_gap.delete();
      @(posedge clk); #1 rst = 1'b0;
      csr_rd("j5_status", 8'd0, 32'd0);
      csr_rd("j5_res_count", 8'd2, 32'd0);
      csr_rd("j5_len", 8'd1, 32'd32);
      csr_wr(8'd1, 32'd4);
      expect_job(1'b1);
      push_beats(6, 1, 0, 2, 0);
      csr_wr(8'd0, 32'd1);
      wait_idle(200);
      csr_rd("j6_status", 8'd0, 32'h2);
      csr_rd("j6_res_count", 8'd2, 32'd4);
      check_drained("j6");
      check_res(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
